// File: rtl/wrr_txn_arbiter_if.sv
// Request/grant bundle shared by the weighted round-robin arbiter and its requesters.
// The master side drives requests and weights; the slave side is the arbiter.
interface wrr_txn_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned WW = 4
);
    localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic            done;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    grant;
    logic [IdW-1:0]  grant_id;
    logic            busy;
    logic            timeout;

    modport master (
        output req, done, weight,
        input  grant, grant_id, busy, timeout
    );

    modport slave (
        input  req, done, weight,
        output grant, grant_id, busy, timeout
    );
endinterface

// File: rtl/wrr_txn_arbiter.sv
// Weighted round-robin transaction arbiter: one grant held per transaction, per-requester
// credits reloaded from weights once a round is spent, and a hold watchdog.
module wrr_txn_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned WW       = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input logic              clk,
    input logic              rst_n,
    wrr_txn_arbiter_if.slave bus
);
    localparam int unsigned IdW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HcW = $clog2(MAX_HOLD);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [IdW-1:0]  gid_q, gid_d;
    logic [HcW-1:0]  hold_q, hold_d;
    logic            timeout_q, timeout_d;
    logic [WW-1:0]   credit_q [N];
    logic [WW-1:0]   credit_d [N];

    logic [N-1:0]    eligible;
    logic [IdW:0]    sel;
    logic            rel;
    logic [IdW-1:0]  next_id;

    // Returns {found, index} of the first set bit at or above start, wrapping at N.
    function automatic logic [IdW:0] pick(input logic [N-1:0] vec, input logic [IdW-1:0] start);
        logic [IdW:0] res;
        int unsigned  idx;
        res = '0;
        for (int i = 0; i < int'(N); i++) begin
            idx = (int'(start) + i) % N;
            if (!res[IdW] && vec[idx]) begin
                res = {1'b1, IdW'(idx)};
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gid_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            credit_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gid_q     <= gid_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            credit_q  <= credit_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gid_d     = gid_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        credit_d  = credit_q;
        eligible  = '0;
        sel       = '0;
        rel       = 1'b0;
        next_id   = (gid_q == IdW'(N - 1)) ? '0 : gid_q + IdW'(1);

        case (state_q)
            StIdle: begin
                for (int i = 0; i < int'(N); i++) begin
                    eligible[i] = bus.req[i] && (credit_q[i] != '0);
                end
                if (eligible != '0) begin
                    sel = pick(eligible, ptr_q);
                end else if (bus.req != '0) begin
                    // Round exhausted: refill every credit; a zero weight still earns one slot.
                    for (int i = 0; i < int'(N); i++) begin
                        credit_d[i] = (bus.weight[i*WW +: WW] == '0) ? WW'(1)
                                                                       : bus.weight[i*WW +: WW];
                    end
                    sel = pick(bus.req, ptr_q);
                end
                if (sel[IdW]) begin
                    state_d = StGrant;
                    gid_d   = sel[IdW-1:0];
                    hold_d  = '0;
                end
            end
            StGrant: begin
                rel = !bus.req[gid_q] || bus.done || (hold_q == HcW'(MAX_HOLD - 1));
                if (rel) begin
                    state_d         = StIdle;
                    credit_d[gid_q] = credit_q[gid_q] - WW'(1);
                    ptr_d           = (credit_q[gid_q] > WW'(1)) ? gid_q : next_id;
                    // Only the watchdog path reaches here with req held and no done.
                    timeout_d       = bus.req[gid_q] && !bus.done;
                end else begin
                    hold_d = hold_q + HcW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.grant = '0;
        if (state_q == StGrant) begin
            bus.grant[gid_q] = 1'b1;
        end
        bus.grant_id = gid_q;
        bus.busy     = (state_q == StGrant);
        bus.timeout  = timeout_q;
    end
endmodule

// File: doc/wrr_txn_arbiter.md
Name: wrr_txn_arbiter

Overview:
- Weighted round-robin transaction arbiter sharing one downstream resource among N requesters.
- Each grant is held for a whole transaction, which ends on `done`, a requester drop or a hold timeout.
- Per-requester credit counters set how many back-to-back transactions each requester gets per round.
- Drop-in successor to the basic 4-way `req`/`grant` arbiter; adds transaction hold, weights and watchdog.

Parameters:
- N, 4, number of requesters (2..16).
- WW, 4, width of each weight/credit field.
- MAX_HOLD, 16, max cycles a grant may stay asserted before forced release (>=2).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  N  request per requester; level, held until served.
- done  input  1  current transaction finished; valid only while grant!=0.
- weight  input  N*WW  packed weights, requester i at [i*WW +: WW]; sampled only on credit reload.
- grant  output  N  one-hot registered grant, or all-zero.
- grant_id  output  $clog2(N)  index of granted requester; holds last winner when grant==0.
- busy  output  1  high while in GRANT state (equals |grant).
- timeout  output  1  one-cycle pulse on forced release by MAX_HOLD.

Behaviour:
- Reset (rst_n==0 at edge, overrides everything, including mid-transaction):
  - grant=0, grant_id=0, busy=0, timeout=0.
  - State=IDLE, ptr=0, hold_cnt=0, all credits=0.
- FSM: IDLE, GRANT.
- IDLE:
  - eligible = req & (credit!=0).
  - If eligible!=0: winner = first set bit of eligible, scanning from ptr upward with wrap.
  - Else if req!=0: reload every credit[i] = (weight[i]==0 ? 1 : weight[i]), then winner = first set bit of req from ptr.
  - If a winner exists: next edge grant=onehot(winner), grant_id=winner, state=GRANT, hold_cnt=0.
  - req==0: stay IDLE; credits unchanged.
- Latency: req sampled in IDLE -> grant asserted the following cycle.
- GRANT (winner w), exit conditions in priority order:
  - a) req[w]==0: release, no timeout.
  - b) done==1: release.
  - c) hold_cnt==MAX_HOLD-1: release and timeout=1 for the next cycle.
  - Otherwise hold_cnt++ and grant holds.
- Release (any cause), at the edge:
  - grant=0, state=IDLE.
  - credit[w] -= 1.
  - ptr = (credit[w] after decrement > 0) ? w : (w+1) mod N.
- After every release, at least one grant-low cycle separates two grants; re-arbitration happens in that IDLE cycle.
- Max grant width is MAX_HOLD cycles.
- Credits never underflow: a winner always has credit >=1 at grant time.
- Changes to `weight` take effect only at the next reload.
- `done` while grant==0 is ignored.
- `req` bits other than w are ignored during GRANT.
- Simultaneous done and timeout condition: treated as done, no timeout pulse.
- ptr wraps N-1 -> 0.
- grant is always zero or one-hot.

Test Plan:
- Weighted rotation:
  - Stimulus: N=4, weight {w3..w0}={1,1,1,2}, req=1111 constant, done pulsed 1 cycle after each grant.
  - Required: grant_id sequence 0,0,1,2,3,0,0,1,2,3.
  - Required: each grant high 1 cycle, separated by 1 low cycle.
- Single requester latency:
  - Stimulus: req=0100 applied in IDLE.
  - Required: grant=0100 exactly 1 cycle later; done after 3 cycles -> grant=0000 next cycle.
- Timeout:
  - Stimulus: MAX_HOLD=8, req=0010 held, done never.
  - Required: grant=0010 for 8 cycles, then grant=0000 with timeout=1 for one cycle.
  - Required: re-grant 0010 on the following cycle.
- Zero weight and requester drop:
  - Stimulus 1: weight1=0, req=0011.
  - Required 1: requester 1 gets exactly one transaction per round.
  - Stimulus 2: drop req[1] mid-grant.
  - Required 2: grant=0000 next cycle, timeout stays 0, ptr advances to 2.
- Reset mid-operation:
  - Stimulus: rst_n=0 for 1 cycle while grant=1000.
  - Required: next cycle grant=0, busy=0, grant_id=0.
  - Required: after release of reset with req=1111, first grant=0001 (reload occurs).
- Done ignored when idle:
  - Stimulus: done=1 with req=0.
  - Required: no grant, credits unchanged; a later req=1000 is granted normally.
